// File: rtl/aib_wb_chan_sel.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : aib_wb_chan_sel
// Brief  : Routes a pipelined Wishbone slave port to one of CHAN_CNT adapter
//          channels, with drain / settle sequencing on runtime re-selection.
// Rev    : 1.0 - initial release
// ============================================================================
module aib_wb_chan_sel #(
  parameter int CHAN_CNT      = 4,
  parameter int SEL_W         = $clog2(CHAN_CNT),
  parameter int MAX_OUTST     = 8,
  parameter int DRAIN_TIMEOUT = 1024,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                  i_sys_clk,
  input  logic                  i_rst_n,
  input  logic [SEL_W-1:0]      c_chan_sel,
  input  logic                  i_timeout_clr,
  input  logic                  i_wb_stb,
  input  logic                  i_wb_we,
  input  logic [31:0]           i_wb_addr,
  input  logic [3:0]            i_wb_sel,
  input  logic [31:0]           i_wb_wdata,
  output logic                  o_wb_stall,
  output logic                  o_wb_ack,
  output logic [31:0]           o_wb_rdata,
  output logic [CHAN_CNT-1:0]   o_ch_en,
  output logic [CHAN_CNT-1:0]   o_ch_stb,
  output logic                  o_ch_we,
  output logic [31:0]           o_ch_addr,
  output logic [3:0]            o_ch_sel,
  output logic [31:0]           o_ch_wdata,
  input  logic [CHAN_CNT-1:0]   i_ch_stall,
  input  logic [CHAN_CNT-1:0]   i_ch_ack,
  input  logic [CHAN_CNT*32-1:0] i_ch_rdata,
  output logic [SEL_W-1:0]      o_active_sel,
  output logic                  o_busy,
  output logic                  o_timeout
);

  localparam int OUT_W   = $clog2(MAX_OUTST + 1);
  localparam int TMR_MAX = (DRAIN_TIMEOUT > SETTLE_CYCLES) ? DRAIN_TIMEOUT : SETTLE_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [1:0] S_ACTIVE = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;

  localparam logic [OUT_W-1:0] c_max_outst   = OUT_W'(MAX_OUTST);
  localparam logic [TMR_W-1:0] c_drain_last  = TMR_W'(DRAIN_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] c_settle_last = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [SEL_W:0]   c_chan_cnt    = (SEL_W + 1)'(CHAN_CNT);

  logic [1:0]          r_state, w_state_nxt;
  logic [SEL_W-1:0]    r_active_sel, w_sel_nxt;
  logic [CHAN_CNT-1:0] r_ch_en, w_en_nxt;
  logic [OUT_W-1:0]    r_outst, w_outst_nxt;
  logic [TMR_W-1:0]    r_timer, w_timer_nxt;
  logic                r_timeout, w_timeout_set;
  logic                r_busy;

  logic                w_req_ok, w_accept, w_sel_stall, w_sel_ack, w_sel_in_range;
  logic [31:0]         w_rdata;
  logic [CHAN_CNT-1:0] w_onehot;

  assign w_onehot       = CHAN_CNT'(1) << r_active_sel;
  assign w_sel_in_range = {1'b0, c_chan_sel} < c_chan_cnt;

  // State register
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_ACTIVE;
      r_active_sel <= '0;
      r_ch_en      <= CHAN_CNT'(1);
      r_outst      <= '0;
      r_timer      <= '0;
      r_timeout    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_active_sel <= w_sel_nxt;
      r_ch_en      <= w_en_nxt;
      r_outst      <= w_outst_nxt;
      r_timer      <= w_timer_nxt;
      r_timeout    <= w_timeout_set | (r_timeout & ~i_timeout_clr);
      r_busy       <= (w_state_nxt != S_ACTIVE);
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt   = r_state;
    w_sel_nxt     = r_active_sel;
    w_en_nxt      = r_ch_en;
    w_timer_nxt   = r_timer;
    w_timeout_set = 1'b0;
    w_outst_nxt   = r_outst;
    if (w_accept && !o_wb_ack)
      w_outst_nxt = r_outst + OUT_W'(1);
    else if (!w_accept && o_wb_ack)
      w_outst_nxt = r_outst - OUT_W'(1);

    case (r_state)
      S_ACTIVE: begin
        if (c_chan_sel != r_active_sel && w_sel_in_range) begin
          w_state_nxt = S_DRAIN;
          w_timer_nxt = '0;
        end
      end
      S_DRAIN: begin
        // A drain that runs out of time abandons the old channel's acks.
        if (w_outst_nxt == '0 || r_timer == c_drain_last) begin
          if (w_outst_nxt != '0) begin
            w_timeout_set = 1'b1;
            w_outst_nxt   = '0;
          end
          w_state_nxt = S_SETTLE;
          w_en_nxt    = '0;
          w_timer_nxt = '0;
          if (w_sel_in_range)
            w_sel_nxt = c_chan_sel;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      S_SETTLE: begin
        if (r_timer == c_settle_last) begin
          w_state_nxt = S_ACTIVE;
          w_en_nxt    = w_onehot;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_ACTIVE;
        w_en_nxt    = w_onehot;
      end
    endcase
  end

  // Output logic
  always_comb begin
    w_req_ok    = (r_state == S_ACTIVE) && (c_chan_sel == r_active_sel) &&
                  (r_outst < c_max_outst);
    w_sel_stall = 1'b0;
    w_sel_ack   = 1'b0;
    w_rdata     = '0;
    for (int k = 0; k < CHAN_CNT; k++) begin
      if (SEL_W'(k) == r_active_sel) begin
        w_sel_stall = i_ch_stall[k];
        w_sel_ack   = i_ch_ack[k];
        w_rdata     = i_ch_rdata[32*k +: 32];
      end
    end
    o_ch_stb   = (i_wb_stb && w_req_ok) ? w_onehot : '0;
    o_wb_stall = !w_req_ok || w_sel_stall;
    o_wb_ack   = w_sel_ack && (r_outst != '0);
    o_wb_rdata = w_rdata;
    w_accept   = i_wb_stb && !o_wb_stall;
  end

  assign o_ch_en      = r_ch_en;
  assign o_ch_we      = i_wb_we;
  assign o_ch_addr    = i_wb_addr;
  assign o_ch_sel     = i_wb_sel;
  assign o_ch_wdata   = i_wb_wdata;
  assign o_active_sel = r_active_sel;
  assign o_busy       = r_busy;
  assign o_timeout    = r_timeout;

endmodule
`default_nettype wire
